// File: rtl/snowbro2_video_pkg.sv
// snowbro2_video_pkg
// Shared timing constants and helpers for the Snow Bros 2 video timing
// generator. The raster is 432 pixels x 262 lines at a 6.75 MHz pixel rate.
// The visible area is 320 x 240. HSYNC is 32 pixels wide and VSYNC is 3 lines
// wide.
package snowbro2_video_pkg;

    localparam int CNT_W        = 9;

    localparam int H_TOTAL      = 432;
    localparam int H_ACTIVE     = 320;
    localparam int H_SYNC_START = 352;
    localparam int H_SYNC_W     = 32;

    localparam int V_TOTAL      = 262;
    localparam int V_ACTIVE     = 240;
    localparam int V_SYNC_START = 244;
    localparam int V_SYNC_W     = 3;

    typedef logic [CNT_W-1:0] cnt_t;

    // Counter-width copies of the constants.
    // They let the decode logic compare like-sized operands.
    localparam cnt_t H_LAST_C        = cnt_t'(H_TOTAL - 1);
    localparam cnt_t H_ACTIVE_C      = cnt_t'(H_ACTIVE);
    localparam cnt_t H_SYNC_START_C  = cnt_t'(H_SYNC_START);
    localparam cnt_t H_SYNC_W_C      = cnt_t'(H_SYNC_W);
    localparam cnt_t V_LAST_C        = cnt_t'(V_TOTAL - 1);
    localparam cnt_t V_ACTIVE_C      = cnt_t'(V_ACTIVE);
    localparam cnt_t V_LAST_ACTIVE_C = cnt_t'(V_ACTIVE - 1);
    localparam cnt_t V_SYNC_START_C  = cnt_t'(V_SYNC_START);
    localparam cnt_t V_SYNC_W_C      = cnt_t'(V_SYNC_W);

    // Returns true when pos lies in the half-open window [first, last).
    function automatic logic in_window(input cnt_t pos, input cnt_t first, input cnt_t last);
        return (pos >= first) && (pos < last);
    endfunction

endpackage

// File: rtl/snowbro2_vbl_irq.sv
// snowbro2_vbl_irq
// Vertical-blank interrupt latch for the 68000. The latch gives a level
// request.
// Ports:
//   clk     - system clock
//   rst_n   - asynchronous active-low reset. It clears any pending request.
//   trigger - one-cycle set pulse at the start of vertical blank
//   ack     - one-cycle CPU acknowledge. It works without regard to the pixel
//             enable.
//   irq     - registered interrupt request level
module snowbro2_vbl_irq
    import snowbro2_video_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic trigger,
    input  logic ack,
    output logic irq
);

    // Set has priority over acknowledge.
    // A new vblank cannot be lost to an ack that arrives in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else if (trigger) begin
            irq <= 1'b1;
        end else if (ack) begin
            irq <= 1'b0;
        end
    end

endmodule

// File: rtl/snowbro2_video_timing.sv
// snowbro2_video_timing
// Raster timing generator for Snow Bros 2. It produces the pixel and line
// counters, the blanking and sync strobes, a frame parity bit and the vblank
// interrupt.
// Ports:
//   CLK      - 47.25 MHz system clock
//   RESETn   - asynchronous active-low reset
//   CEN675   - 6.75 MHz pixel enable. It is one CLK wide.
//   HOFFSET  - signed horizontal sync shift, in pixels
//   VOFFSET  - signed vertical sync shift, in lines
//   INT_ACK  - CPU vblank interrupt acknowledge pulse
//   HCNT     - pixel counter, 0..431
//   VCNT     - line counter, 0..261
//   HBLANK, VBLANK, HSYNC, VSYNC - active-high timing strobes
//   INT_VBL  - level interrupt request
//   FRAME    - toggles on each frame wrap
// Configuration:
//   SNOWBRO2_VTIMING_ADJ_EN - when defined, HOFFSET and VOFFSET move the sync
//   pulses. When it is not defined, both ports are ignored.
module snowbro2_video_timing
    import snowbro2_video_pkg::*;
(
    input  logic       CLK,
    input  logic       RESETn,
    input  logic       CEN675,
    input  logic [3:0] HOFFSET,
    input  logic [2:0] VOFFSET,
    input  logic       INT_ACK,
    output logic [8:0] HCNT,
    output logic [8:0] VCNT,
    output logic       HBLANK,
    output logic       VBLANK,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       INT_VBL,
    output logic       FRAME
);

    cnt_t h_next;
    cnt_t v_next;
    logic h_wrap;
    logic v_wrap;
    cnt_t hs_start;
    cnt_t hs_end;
    cnt_t vs_start;
    cnt_t vs_end;
    logic irq_set;

`ifdef SNOWBRO2_VTIMING_ADJ_EN
    // Sign-extend the offsets to counter width.
    // Two's-complement wrap then gives the subtraction for negative shifts.
    assign hs_start = H_SYNC_START_C + {{(CNT_W-4){HOFFSET[3]}}, HOFFSET};
    assign vs_start = V_SYNC_START_C + {{(CNT_W-3){VOFFSET[2]}}, VOFFSET};
`else
    logic unused_offsets;
    assign unused_offsets = ^{HOFFSET, VOFFSET};
    assign hs_start = H_SYNC_START_C;
    assign vs_start = V_SYNC_START_C;
`endif

    assign hs_end = hs_start + H_SYNC_W_C;
    assign vs_end = vs_start + V_SYNC_W_C;

    // Next-position logic.
    // The strobes are decoded from the next counter values and registered at
    // the same time as the counters. This keeps them aligned with the HCNT and
    // VCNT values they describe.
    always_comb begin
        h_wrap = (HCNT == H_LAST_C);
        v_wrap = h_wrap && (VCNT == V_LAST_C);
        h_next = h_wrap ? '0 : HCNT + cnt_t'(1);
        v_next = VCNT;
        if (h_wrap) begin
            v_next = v_wrap ? '0 : VCNT + cnt_t'(1);
        end
    end

    // Counters and strobes. All of them advance only on pixel-enable cycles.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            HCNT   <= '0;
            VCNT   <= '0;
            HBLANK <= 1'b0;
            VBLANK <= 1'b0;
            HSYNC  <= 1'b0;
            VSYNC  <= 1'b0;
            FRAME  <= 1'b0;
        end else if (CEN675) begin
            HCNT   <= h_next;
            VCNT   <= v_next;
            HBLANK <= (h_next >= H_ACTIVE_C);
            VBLANK <= (v_next >= V_ACTIVE_C);
            HSYNC  <= in_window(h_next, hs_start, hs_end);
            VSYNC  <= in_window(v_next, vs_start, vs_end);
            if (v_wrap) begin
                FRAME <= ~FRAME;
            end
        end
    end

    // The interrupt sets on the enable that moves the raster from the last
    // active line into line 240, pixel 0.
    assign irq_set = CEN675 && h_wrap && (VCNT == V_LAST_ACTIVE_C);

    snowbro2_vbl_irq u_vbl_irq (
        .clk     (CLK),
        .rst_n   (RESETn),
        .trigger (irq_set),
        .ack     (INT_ACK),
        .irq     (INT_VBL)
    );

endmodule

// File: tb/tb_snowbro2_video_timing.sv
// tb_snowbro2_video_timing
// Directed self-checking bench for snowbro2_video_timing.
// Define SNOWBRO2_VTIMING_ADJ_EN to build it against the sync-offset variant.
module tb_snowbro2_video_timing;

    logic       CLK = 1'b0;
    logic       RESETn;
    logic       CEN675;
    logic [3:0] HOFFSET;
    logic [2:0] VOFFSET;
    logic       INT_ACK;
    logic [8:0] HCNT;
    logic [8:0] VCNT;
    logic       HBLANK;
    logic       VBLANK;
    logic       HSYNC;
    logic       VSYNC;
    logic       INT_VBL;
    logic       FRAME;

    int checks   = 0;
    int failures = 0;

`ifdef SNOWBRO2_VTIMING_ADJ_EN
    localparam int EXP_HS = 344;
    localparam int EXP_VS = 247;
`else
    localparam int EXP_HS = 352;
    localparam int EXP_VS = 244;
`endif

    // Raster position model, advanced once per enable
    int exp_h;
    int exp_v;
    int exp_wraps;

    // Free-run measurements
    bit mon_on;
    int en_idx;
    int last_h0;
    int h_periods;
    int h_period_bad;
    bit seen_v0;
    int lines_since_v0;
    int v_lines_last;
    int v_periods;
    int toggles;
    bit last_frame;
    int hb_run;
    int hb_runs;
    int hb_bad;
    int vb_lines;
    int vb_runs;
    int vb_bad;

    snowbro2_video_timing dut (
        .CLK     (CLK),
        .RESETn  (RESETn),
        .CEN675  (CEN675),
        .HOFFSET (HOFFSET),
        .VOFFSET (VOFFSET),
        .INT_ACK (INT_ACK),
        .HCNT    (HCNT),
        .VCNT    (VCNT),
        .HBLANK  (HBLANK),
        .VBLANK  (VBLANK),
        .HSYNC   (HSYNC),
        .VSYNC   (VSYNC),
        .INT_VBL (INT_VBL),
        .FRAME   (FRAME)
    );

    always #5 CLK = ~CLK;

    initial begin
        #10000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic monitor_sample();
        en_idx++;
        if (FRAME !== last_frame) toggles++;
        last_frame = FRAME;
        if (HBLANK) begin
            hb_run++;
        end else if (hb_run > 0) begin
            hb_runs++;
            if (hb_run != 112) hb_bad++;
            hb_run = 0;
        end
        if (HCNT == 9'd0) begin
            if (last_h0 >= 0) begin
                h_periods++;
                if (en_idx - last_h0 != 432) h_period_bad++;
            end
            last_h0 = en_idx;
            lines_since_v0++;
            if (VBLANK) begin
                vb_lines++;
            end else if (vb_lines > 0) begin
                vb_runs++;
                if (vb_lines != 22) vb_bad++;
                vb_lines = 0;
            end
            if (VCNT == 9'd0) begin
                if (seen_v0) begin
                    v_periods++;
                    v_lines_last = lines_since_v0;
                end
                seen_v0 = 1'b1;
                lines_since_v0 = 0;
            end
        end
    endtask

    // Entered and left at a falling clock edge. It gives one pixel enable and
    // then waits out the rest of the gap.
    task automatic advance(input int gap, input bit ack);
        INT_ACK = ack;
        CEN675  = 1'b1;
        @(negedge CLK);
        CEN675  = 1'b0;
        INT_ACK = 1'b0;
        if (exp_h == 431) begin
            exp_h = 0;
            if (exp_v == 261) begin
                exp_v = 0;
                exp_wraps++;
            end else begin
                exp_v++;
            end
        end else begin
            exp_h++;
        end
        if (mon_on) monitor_sample();
        repeat (gap - 1) @(negedge CLK);
    endtask

    task automatic test_reset();
        RESETn  = 1'b0;
        CEN675  = 1'b0;
        INT_ACK = 1'b0;
        HOFFSET = 4'b1000;
        VOFFSET = 3'd3;
        exp_h = 0; exp_v = 0; exp_wraps = 0;
        repeat (3) @(negedge CLK);
        CEN675 = 1'b1;
        repeat (2) @(negedge CLK);
        CEN675 = 1'b0;
        checks++;
        if (HCNT !== 9'd0) begin
            failures++; $display("[TB] FAIL reset_hcnt: got %0d expected 0", HCNT);
        end
        checks++;
        if (VCNT !== 9'd0) begin
            failures++; $display("[TB] FAIL reset_vcnt: got %0d expected 0", VCNT);
        end
        checks++;
        if ({HBLANK, VBLANK, HSYNC, VSYNC, INT_VBL, FRAME} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags: got %b expected 000000",
                     {HBLANK, VBLANK, HSYNC, VSYNC, INT_VBL, FRAME});
        end
        RESETn = 1'b1;
    endtask

    task automatic test_first_enable();
        advance(7, 1'b0);
        checks++;
        if (HCNT !== 9'd1) begin
            failures++; $display("[TB] FAIL first_hcnt: got %0d expected 1", HCNT);
        end
        checks++;
        if (VCNT !== 9'd0) begin
            failures++; $display("[TB] FAIL first_vcnt: got %0d expected 0", VCNT);
        end
    endtask

    task automatic test_line_timing();
        int hb_first = -1;
        int hb_cnt   = 0;
        int h_last   = -1;
        while (exp_h != 0) begin
            advance(7, 1'b0);
            if (exp_h == 431) h_last = int'(HCNT);
            if (HBLANK) begin
                hb_cnt++;
                if (hb_first < 0) hb_first = int'(HCNT);
            end
        end
        checks++;
        if (h_last != 431) begin
            failures++; $display("[TB] FAIL line_last_hcnt: got %0d expected 431", h_last);
        end
        checks++;
        if (hb_first != 320) begin
            failures++; $display("[TB] FAIL hblank_start: got %0d expected 320", hb_first);
        end
        checks++;
        if (hb_cnt != 112) begin
            failures++; $display("[TB] FAIL hblank_width: got %0d expected 112", hb_cnt);
        end
        checks++;
        if (HCNT !== 9'd0 || VCNT !== 9'd1) begin
            failures++;
            $display("[TB] FAIL line_wrap: got h=%0d v=%0d expected h=0 v=1", HCNT, VCNT);
        end
    endtask

    task automatic test_cen_gap();
        while (exp_h != 100) advance(1, 1'b0);
        repeat (50) begin
            @(negedge CLK);
            checks++;
            if (HCNT !== 9'd100 || VCNT !== 9'd1 ||
                {HBLANK, VBLANK, HSYNC, VSYNC, INT_VBL, FRAME} !== 6'b0) begin
                failures++;
                $display("[TB] FAIL cen_gap_hold: got h=%0d v=%0d flags=%b expected h=100 v=1 flags=000000",
                         HCNT, VCNT, {HBLANK, VBLANK, HSYNC, VSYNC, INT_VBL, FRAME});
            end
        end
        advance(1, 1'b0);
        checks++;
        if (HCNT !== 9'd101 || VCNT !== 9'd1) begin
            failures++;
            $display("[TB] FAIL cen_gap_resume: got h=%0d v=%0d expected h=101 v=1", HCNT, VCNT);
        end
    endtask

    task automatic test_irq_coincident();
        while (!(exp_v == 239 && exp_h == 431)) advance(1, 1'b0);
        checks++;
        if (INT_VBL !== 1'b0 || VBLANK !== 1'b0) begin
            failures++;
            $display("[TB] FAIL pre_vbl: got int=%b vblank=%b expected 0 0", INT_VBL, VBLANK);
        end
        advance(1, 1'b1);
        checks++;
        if (INT_VBL !== 1'b1) begin
            failures++; $display("[TB] FAIL irq_set_wins: got %b expected 1", INT_VBL);
        end
        checks++;
        if (VCNT !== 9'd240 || HCNT !== 9'd0 || VBLANK !== 1'b1) begin
            failures++;
            $display("[TB] FAIL vbl_start: got v=%0d h=%0d vblank=%b expected v=240 h=0 vblank=1",
                     VCNT, HCNT, VBLANK);
        end
    endtask

    task automatic test_offsets();
        int hs_rise  = -1;
        int hs_w     = 0;
        int vs_rise  = -1;
        int vs_lines = 0;
        bit prev_hs  = 1'b0;
        bit prev_vs  = 1'b0;
        while (!(exp_v == 250 && exp_h == 0)) begin
            advance(1, 1'b0);
            if (HSYNC && !prev_hs && hs_rise < 0) hs_rise = int'(HCNT);
            if (HSYNC && exp_v == 240) hs_w++;
            if (VSYNC && !prev_vs && vs_rise < 0) vs_rise = int'(VCNT);
            if (VSYNC && exp_h == 0) vs_lines++;
            prev_hs = HSYNC;
            prev_vs = VSYNC;
        end
        checks++;
        if (hs_rise != EXP_HS) begin
            failures++; $display("[TB] FAIL hsync_start: got %0d expected %0d", hs_rise, EXP_HS);
        end
        checks++;
        if (hs_w != 32) begin
            failures++; $display("[TB] FAIL hsync_width: got %0d expected 32", hs_w);
        end
        checks++;
        if (vs_rise != EXP_VS) begin
            failures++; $display("[TB] FAIL vsync_start: got %0d expected %0d", vs_rise, EXP_VS);
        end
        checks++;
        if (vs_lines != 3) begin
            failures++; $display("[TB] FAIL vsync_width: got %0d expected 3", vs_lines);
        end
    endtask

    task automatic test_reset_mid_frame();
        while (!(exp_v == 250 && exp_h == 10)) advance(1, 1'b0);
        checks++;
        if (VCNT !== 9'd250 || INT_VBL !== 1'b1) begin
            failures++;
            $display("[TB] FAIL pre_reset: got v=%0d int=%b expected v=250 int=1", VCNT, INT_VBL);
        end
        #2;
        RESETn = 1'b0;
        #1;
        checks++;
        if (HCNT !== 9'd0 || VCNT !== 9'd0 ||
            {HBLANK, VBLANK, HSYNC, VSYNC, INT_VBL, FRAME} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL async_reset: got h=%0d v=%0d flags=%b expected all 0",
                     HCNT, VCNT, {HBLANK, VBLANK, HSYNC, VSYNC, INT_VBL, FRAME});
        end
        @(negedge CLK);
        repeat (2) @(negedge CLK);
        RESETn = 1'b1;
        exp_h = 0; exp_v = 0; exp_wraps = 0;
        advance(7, 1'b0);
        checks++;
        if (HCNT !== 9'd1 || VCNT !== 9'd0 || INT_VBL !== 1'b0 || FRAME !== 1'b0) begin
            failures++;
            $display("[TB] FAIL post_reset: got h=%0d v=%0d int=%b frame=%b expected h=1 v=0 int=0 frame=0",
                     HCNT, VCNT, INT_VBL, FRAME);
        end
    endtask

    task automatic start_monitor();
        en_idx = 0; last_h0 = -1; h_periods = 0; h_period_bad = 0;
        seen_v0 = 1'b0; lines_since_v0 = 0; v_lines_last = 0; v_periods = 0;
        toggles = 0; last_frame = 1'b0;
        hb_run = 0; hb_runs = 0; hb_bad = 0;
        vb_lines = 0; vb_runs = 0; vb_bad = 0;
        mon_on = 1'b1;
    endtask

    task automatic test_irq_ack();
        while (!(exp_v == 239 && exp_h == 431)) advance(1, 1'b0);
        checks++;
        if (INT_VBL !== 1'b0) begin
            failures++; $display("[TB] FAIL irq_idle: got %b expected 0", INT_VBL);
        end
        advance(1, 1'b0);
        checks++;
        if (INT_VBL !== 1'b1 || VCNT !== 9'd240 || HCNT !== 9'd0) begin
            failures++;
            $display("[TB] FAIL irq_rise: got int=%b v=%0d h=%0d expected int=1 v=240 h=0",
                     INT_VBL, VCNT, HCNT);
        end
        repeat (99) advance(1, 1'b0);
        checks++;
        if (INT_VBL !== 1'b1) begin
            failures++; $display("[TB] FAIL irq_held: got %b expected 1", INT_VBL);
        end
        INT_ACK = 1'b1;
        @(negedge CLK);
        INT_ACK = 1'b0;
        checks++;
        if (INT_VBL !== 1'b0) begin
            failures++; $display("[TB] FAIL irq_ack: got %b expected 0", INT_VBL);
        end
        checks++;
        if (HCNT !== 9'd99) begin
            failures++; $display("[TB] FAIL ack_no_advance: got %0d expected 99", HCNT);
        end
    endtask

    task automatic test_free_run();
        while (exp_wraps < 2) advance(1, 1'b0);
        mon_on = 1'b0;
        checks++;
        if (h_periods != 523 || h_period_bad != 0) begin
            failures++;
            $display("[TB] FAIL h_period: got %0d periods %0d wrong expected 523 periods 0 wrong",
                     h_periods, h_period_bad);
        end
        checks++;
        if (v_periods != 1 || v_lines_last != 262) begin
            failures++;
            $display("[TB] FAIL v_period: got %0d periods of %0d lines expected 1 of 262",
                     v_periods, v_lines_last);
        end
        checks++;
        if (toggles != 2) begin
            failures++; $display("[TB] FAIL frame_toggles: got %0d expected 2", toggles);
        end
        checks++;
        if (hb_runs != 524 || hb_bad != 0) begin
            failures++;
            $display("[TB] FAIL hblank_runs: got %0d runs %0d wrong expected 524 runs 0 wrong",
                     hb_runs, hb_bad);
        end
        checks++;
        if (vb_runs != 2 || vb_bad != 0) begin
            failures++;
            $display("[TB] FAIL vblank_runs: got %0d runs %0d wrong expected 2 runs 0 wrong",
                     vb_runs, vb_bad);
        end
        checks++;
        if (HCNT !== 9'd0 || VCNT !== 9'd0 || FRAME !== 1'b0) begin
            failures++;
            $display("[TB] FAIL frame_end: got h=%0d v=%0d frame=%b expected 0 0 0", HCNT, VCNT, FRAME);
        end
    endtask

    initial begin
        mon_on = 1'b0;
        test_reset();
        test_first_enable();
        test_line_timing();
        test_cen_gap();
        test_irq_coincident();
        test_offsets();
        test_reset_mid_frame();
        start_monitor();
        test_irq_ack();
        test_free_run();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
